// File: rtl/memory_single_port.sv
// Single-port synchronous RAM bank: 1-cycle registered read, synchronous write, output enable.
// Optional per-word even-parity storage with a sticky error flag when MEM_PARITY_EN is defined.
module memory_single_port #(
   parameter int data_0_WIDTH = 8,
   parameter int ADDR_WIDTH   = 11
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [ADDR_WIDTH-1:0]   address_0,
   input  logic [data_0_WIDTH-1:0] data_0_in,
   output logic [data_0_WIDTH-1:0] data_0_out,
   input  logic                    cs_0,
   input  logic                    we_0,
   input  logic                    oe_0
`ifdef MEM_PARITY_EN
   ,
   output logic                    parity_err,
   input  logic                    par_inj_0
`endif
);

   localparam int DEPTH = 1 << ADDR_WIDTH;

   logic [data_0_WIDTH-1:0] mem [DEPTH];
   logic [data_0_WIDTH-1:0] rd_q;
   logic                    wr_en;
   logic                    rd_en;

   // Reset low blocks both access kinds; an in-flight access is simply dropped.
   assign wr_en = reset & cs_0 & we_0;
   assign rd_en = reset & cs_0 & ~we_0;

   // NOTE: the array has no reset branch so it maps onto RAM macros and keeps contents across reset.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[address_0] <= data_0_in;
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_q <= '0;
      end else if (rd_en) begin
         rd_q <= mem[address_0];
      end
   end

   assign data_0_out = oe_0 ? rd_q : '0;

`ifdef MEM_PARITY_EN
   logic par_mem [DEPTH];
   logic par_bad;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         par_mem[address_0] <= (^data_0_in) ^ par_inj_0;
      end
   end

   assign par_bad = (^mem[address_0]) != par_mem[address_0];

   // Flag rises on the same edge that loads rd_q and stays set until reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         parity_err <= 1'b0;
      end else if (rd_en && par_bad) begin
         parity_err <= 1'b1;
      end
   end
`endif

endmodule

// File: tb/tb_memory_single_port.sv
// Self-checking bench for memory_single_port: vector table plus hand-written reset,
// output-enable, streaming and (with MEM_PARITY_EN) parity sequences.
module tb_memory_single_port;

   logic        clk = 1'b0;
   logic        reset;
   logic [10:0] address_0;
   logic [7:0]  data_0_in;
   logic [7:0]  data_0_out;
   logic        cs_0;
   logic        we_0;
   logic        oe_0;
`ifdef MEM_PARITY_EN
   logic        parity_err;
   logic        par_inj_0;
`endif

   int n_cmp = 0;
   int n_err = 0;

   typedef struct {
      logic        cs;
      logic        we;
      logic        oe;
      logic [10:0] addr;
      logic [7:0]  din;
      logic [7:0]  exp_out;
      string       name;
   } vec_t;

   vec_t tbl [12];

   memory_single_port #(.data_0_WIDTH(8), .ADDR_WIDTH(11)) dut (
      .clk        (clk),
      .reset      (reset),
      .address_0  (address_0),
      .data_0_in  (data_0_in),
      .data_0_out (data_0_out),
      .cs_0       (cs_0),
      .we_0       (we_0),
      .oe_0       (oe_0)
`ifdef MEM_PARITY_EN
      ,
      .parity_err (parity_err),
      .par_inj_0  (par_inj_0)
`endif
   );

   always #5 clk = ~clk;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "timeout");
   end

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = '{1'b1, 1'b1, 1'b1, 11'h000, 8'hA5, 8'h00, "wr_a5_at_0"};
      tbl[1]  = '{1'b1, 1'b1, 1'b1, 11'h7FF, 8'h5A, 8'h00, "wr_5a_at_7ff"};
      tbl[2]  = '{1'b1, 1'b0, 1'b1, 11'h7FF, 8'h00, 8'h5A, "rd_7ff"};
      tbl[3]  = '{1'b1, 1'b0, 1'b1, 11'h000, 8'h00, 8'hA5, "rd_0"};
      tbl[4]  = '{1'b1, 1'b1, 1'b1, 11'h005, 8'h11, 8'hA5, "wr_11_at_5_holds_rd"};
      tbl[5]  = '{1'b0, 1'b1, 1'b1, 11'h005, 8'h22, 8'hA5, "wr_22_cs_off"};
      tbl[6]  = '{1'b1, 1'b0, 1'b1, 11'h005, 8'h00, 8'h11, "rd_5_gated_write"};
      tbl[7]  = '{1'b0, 1'b0, 1'b1, 11'h7FF, 8'h00, 8'h11, "rd_cs_off_holds"};
      tbl[8]  = '{1'b1, 1'b1, 1'b1, 11'h003, 8'h3C, 8'h11, "wr_3c_at_3"};
      tbl[9]  = '{1'b1, 1'b0, 1'b1, 11'h003, 8'h00, 8'h3C, "rd_3"};
      tbl[10] = '{1'b0, 1'b0, 1'b0, 11'h000, 8'h00, 8'h00, "oe_off"};
      tbl[11] = '{1'b0, 1'b0, 1'b1, 11'h000, 8'h00, 8'h3C, "oe_on_no_read"};

      reset     = 1'b0;
      cs_0      = 1'b0;
      we_0      = 1'b0;
      oe_0      = 1'b1;
      address_0 = '0;
      data_0_in = '0;
`ifdef MEM_PARITY_EN
      par_inj_0 = 1'b0;
`endif
      #1;
      check("reset_out_zero", data_0_out, 8'h00);
      tick();
      tick();
      @(negedge clk);
      reset = 1'b1;
      tick();
      tick();
      check("after_release_zero", data_0_out, 8'h00);

      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         cs_0      = tbl[i].cs;
         we_0      = tbl[i].we;
         oe_0      = tbl[i].oe;
         address_0 = tbl[i].addr;
         data_0_in = tbl[i].din;
         tick();
         check(tbl[i].name, data_0_out, tbl[i].exp_out);
      end

      // Output enable is combinational: no clock edge between these checks.
      oe_0 = 1'b0;
      #1;
      check("oe_drop_comb", data_0_out, 8'h00);
      oe_0 = 1'b1;
      #1;
      check("oe_raise_comb", data_0_out, 8'h3C);

      // Reset during a write burst: output clears at once, write is dropped, array kept.
      @(negedge clk);
      cs_0      = 1'b1;
      we_0      = 1'b1;
      address_0 = 11'h000;
      data_0_in = 8'h77;
      #1;
      reset = 1'b0;
      #1;
      check("async_reset_out", data_0_out, 8'h00);
      tick();
      tick();
      @(negedge clk);
      cs_0  = 1'b0;
      we_0  = 1'b0;
      reset = 1'b1;
      tick();
      check("idle_after_reset", data_0_out, 8'h00);
      @(negedge clk);
      cs_0      = 1'b1;
      address_0 = 11'h000;
      tick();
      check("mem_kept_write_blocked", data_0_out, 8'hA5);

      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         cs_0      = 1'b1;
         we_0      = 1'b1;
         address_0 = 11'(i);
         data_0_in = 8'(i);
         tick();
      end
      for (int i = 0; i < 128; i++) begin
         @(negedge clk);
         we_0      = 1'b0;
         address_0 = 11'(i);
         tick();
         check($sformatf("stream_rd_%0d", i), data_0_out, 8'(i));
      end

`ifdef MEM_PARITY_EN
      check("parity_clean_reads", {7'd0, parity_err}, 8'h00);
      @(negedge clk);
      we_0      = 1'b1;
      address_0 = 11'h009;
      data_0_in = 8'h0F;
      par_inj_0 = 1'b1;
      tick();
      check("parity_after_write", {7'd0, parity_err}, 8'h00);
      @(negedge clk);
      we_0      = 1'b0;
      par_inj_0 = 1'b0;
      tick();
      check("parity_set_on_read", {7'd0, parity_err}, 8'h01);
      check("parity_read_data", data_0_out, 8'h0F);
      @(negedge clk);
      cs_0 = 1'b0;
      tick();
      check("parity_sticky", {7'd0, parity_err}, 8'h01);
      reset = 1'b0;
      #1;
      check("parity_reset_clear", {7'd0, parity_err}, 8'h00);
      @(negedge clk);
      reset = 1'b1;
      tick();
`endif

      cs_0 = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
